// File: rtl/nv_mem_loader_if.sv
// Byte-stream input and memory write port of the non-volatile memory loader.
// Latency: none, signal bundle only.
// Backpressure: s_ready qualifies s_valid/s_data; the memory side has no backpressure.
interface nv_mem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int BYTE_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [BYTE_W-1:0] s_data;
    logic              mem_w;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              busy;
    logic              done;
    logic              err;

    // Stream source and memory-side observer
    modport master (
        output s_valid, s_data,
        input  s_ready, mem_w, mem_addr, mem_data, busy, done, err
    );

    // The loader itself
    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_w, mem_addr, mem_data, busy, done, err
    );
endinterface

// File: rtl/nv_mem_loader.sv
// Write sequencer: header (addr, count) then payload bytes packed MSB first into words, one mem_w strobe per word.
// Latency: mem_w rises the cycle after the last byte of a word; done follows the final write (or checksum byte).
// Backpressure: s_ready drops for one WRITE cycle per word and in DONE; optional trailing checksum under NV_MEM_LOADER_CHECKSUM_EN.
module nv_mem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int BYTE_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    nv_mem_loader_if.slave  bus
);
    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int REM_W  = ADDR_W + 1;   // holds 2^ADDR_W for a zero count field
    localparam int ACC_W  = DATA_W - BYTE_W;

`ifdef NV_MEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR_CNT, DATA, WRITE, CHK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR_CNT, DATA, WRITE, DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic              xfer;
    logic              last_byte;
    logic              ready_d;

    logic [ADDR_W-1:0] addr_q;
    logic [REM_W-1:0]  rem_q;
    logic [IDX_W-1:0]  idx_q;
    // Only the first NBYTES-1 bytes are buffered; the last byte goes straight into mem_data.
    logic [ACC_W-1:0]  acc_q;

    logic              s_ready_q;
    logic              mem_w_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              busy_q;
    logic              done_q;

    assign xfer      = bus.s_valid && s_ready_q;
    assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and the ready value for the coming cycle
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE:    if (xfer) state_d = HDR_CNT;
            HDR_CNT: if (xfer) state_d = DATA;
            DATA:    if (xfer && last_byte) state_d = WRITE;
            WRITE: begin
                if (rem_q == REM_W'(1)) begin
`ifdef NV_MEM_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = DATA;
                end
            end
`ifdef NV_MEM_LOADER_CHECKSUM_EN
            CHK:     if (xfer) state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        case (state_d)
            IDLE, HDR_CNT, DATA: ready_d = 1'b1;
`ifdef NV_MEM_LOADER_CHECKSUM_EN
            CHK:                 ready_d = 1'b1;
`endif
            default:             ready_d = 1'b0;
        endcase
    end

    // Registered status/strobe outputs, derived from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready_q <= 1'b0;
            mem_w_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            s_ready_q <= ready_d;
            mem_w_q   <= (state_d == WRITE);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
        end
    end

    // Header capture, word assembly, address/count stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) addr_q <= ADDR_W'(bus.s_data);
                end
                HDR_CNT: begin
                    if (xfer) begin
                        if (ADDR_W'(bus.s_data) == '0) rem_q <= {1'b1, {ADDR_W{1'b0}}};
                        else                           rem_q <= {1'b0, ADDR_W'(bus.s_data)};
                        idx_q <= '0;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        acc_q <= {acc_q[ACC_W-BYTE_W-1:0], bus.s_data};
                        idx_q <= last_byte ? '0 : idx_q + IDX_W'(1);
                        if (last_byte) begin
                            mem_addr_q <= addr_q;
                            mem_data_q <= {acc_q, bus.s_data};
                        end
                    end
                end
                WRITE: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    rem_q  <= rem_q - REM_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef NV_MEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q;
    logic              err_q;

    // Running XOR over payload bytes; err is sticky until the next header starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        csum_q <= '0;
                        err_q  <= 1'b0;
                    end
                end
                DATA: if (xfer) csum_q <= csum_q ^ bus.s_data;
                CHK:  if (xfer && (bus.s_data != csum_q)) err_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.s_ready  = s_ready_q;
    assign bus.mem_w    = mem_w_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_nv_mem_loader.sv
// Bench for nv_mem_loader: table of header/payload transactions with a write scoreboard.
// Latency: checks mem_w one cycle after each word's last byte and done placement after the final write.
// Backpressure: random s_valid gaps, s_ready low during WRITE, reset abort mid-payload.
module tb_nv_mem_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nv_mem_loader_if bus ();
    nv_mem_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  cnt;
        logic [63:0] w0;
        logic [63:0] w1;
        bit          gaps;
        bit          bad;
        int          exp_nw;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [63:0] data;
    } exp_t;

    exp_t       sb[$];
    vec_t       vt[8];
    int         n_vec = 0;
    int         n_bad = 0;
    int         n_w = 0;
    bit         first_seen = 0;
    logic [7:0] first_addr = '0;
    logic [7:0] last_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] c, input logic [63:0] w0,
                                input logic [63:0] w1, input bit g, input bit bad, input int nw,
                                input logic [7:0] ef, input logic [7:0] el);
        vec_t v;
        v.addr = a; v.cnt = c; v.w0 = w0; v.w1 = w1; v.gaps = g; v.bad = bad;
        v.exp_nw = nw; v.exp_first = ef; v.exp_last = el;
        return v;
    endfunction

    function automatic logic [63:0] word_of(input vec_t v, input int i);
        logic [31:0] lo;
        if (i == 0) return v.w0;
        if (i == 1) return v.w1;
        lo = v.w0[31:0];
        return {lo ^ 32'(i), 32'(i * 7 + 3)};
    endfunction

    // Write monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.mem_w) begin
            exp_t e;
            n_w++;
            if (!first_seen) begin
                first_addr = bus.mem_addr;
                first_seen = 1'b1;
            end
            last_addr = bus.mem_addr;
            check("wr_ready_low", 64'(bus.s_ready), 64'd0);
            check("wr_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
                check("wr_data", bus.mem_data, e.data);
            end
        end
    end

    // Offer one byte at a negedge; returns at the negedge after it transfers
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g;
        bit ok;
        ok = 1'b0;
        g = gaps ? int'($urandom_range(0, 2)) : 0;
        bus.s_valid = 1'b0;
        repeat (g) begin
            bus.s_data = 8'($urandom);
            @(negedge clk);
        end
        bus.s_valid = 1'b1;
        bus.s_data = b;
        for (int t = 0; t < 64; t++) begin
            ok = bus.s_ready;
            @(negedge clk);
            if (ok) break;
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: byte %0h never accepted", b);
        end
        bus.s_valid = 1'b0;
        bus.s_data = 8'($urandom);
    endtask

    task automatic run_txn(input vec_t v);
        int          base_w, nw, lat;
        bit          got;
        logic [7:0]  a, x, b;
        logic [63:0] w;
        bit          exp_err;
`ifdef NV_MEM_LOADER_CHECKSUM_EN
        exp_err = v.bad;
`else
        exp_err = 1'b0;
`endif
        base_w = n_w;
        first_seen = 1'b0;
        send_byte(v.addr, v.gaps);
        check("err_clear_on_hdr", 64'(bus.err), 64'd0);
        check("busy_after_hdr", 64'(bus.busy), 64'd1);
        send_byte(v.cnt, v.gaps);
        nw = (v.cnt == 8'd0) ? 256 : int'(v.cnt);
        a = v.addr;
        x = '0;
        for (int i = 0; i < nw; i++) begin
            w = word_of(v, i);
            for (int j = 0; j < 8; j++) begin
                b = w[63 - 8 * j -: 8];
                x = x ^ b;
                if (j == 7) sb.push_back('{addr: a, data: w});
                send_byte(b, v.gaps);
            end
            a = a + 8'd1;
        end
`ifdef NV_MEM_LOADER_CHECKSUM_EN
        send_byte(v.bad ? (x ^ 8'h08) : x, v.gaps);
`endif
        got = 1'b0;
        lat = 0;
        for (int t = 0; t < 16; t++) begin
            if (bus.done) begin
                got = 1'b1;
                lat = t;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", 64'(got), 64'd1);
`ifdef NV_MEM_LOADER_CHECKSUM_EN
        check("done_latency", 64'(lat), 64'd0);
`else
        check("done_latency", 64'(lat), 64'd1);
`endif
        check("busy_in_done", 64'(bus.busy), 64'd1);
        check("err_at_done", 64'(bus.err), 64'(exp_err));
        check("num_writes", 64'(n_w - base_w), 64'(v.exp_nw));
        check("first_addr", 64'(first_addr), 64'(v.exp_first));
        check("last_addr", 64'(last_addr), 64'(v.exp_last));
        check("sb_drained", 64'(sb.size()), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("busy_idle", 64'(bus.busy), 64'd0);
        check("ready_idle", 64'(bus.s_ready), 64'd1);
        check("addr_hold", 64'(bus.mem_addr), 64'(v.exp_last));
        check("err_hold", 64'(bus.err), 64'(exp_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
        check({tag, "_mem_w"}, 64'(bus.mem_w), 64'd0);
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        check({tag, "_mem_data"}, bus.mem_data, 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_err"}, 64'(bus.err), 64'd0);
    endtask

    initial begin
        int base_w;
        vt[0] = mk(8'h00, 8'h01, 64'd256, 64'd0, 1'b0, 1'b0, 1, 8'h00, 8'h00);
        vt[1] = mk(8'hFF, 8'h02, 64'd555, 64'd2560, 1'b0, 1'b0, 2, 8'hFF, 8'h00);
        vt[2] = mk(8'hFF, 8'h02, 64'd555, 64'd2560, 1'b1, 1'b0, 2, 8'hFF, 8'h00);
        vt[3] = mk(8'h40, 8'h03, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3, 8'h40, 8'h42);
        vt[4] = mk(8'h30, 8'h01, 64'h0102_0304_0506_0708, 64'd0, 1'b0, 1'b0, 1, 8'h30, 8'h30);
        vt[5] = mk(8'h30, 8'h01, 64'h0102_0304_0506_0708, 64'd0, 1'b0, 1'b1, 1, 8'h30, 8'h30);
        vt[6] = mk(8'h31, 8'h01, 64'h0000_0000_0000_0055, 64'd0, 1'b1, 1'b0, 1, 8'h31, 8'h31);
        vt[7] = mk(8'h10, 8'h00, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, 1'b0, 256, 8'h10, 8'h0F);

        bus.s_valid = 1'b0;
        bus.s_data = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(bus.s_ready), 64'd1);
        check("busy_after_reset", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 8; i++) run_txn(vt[i]);

        // Abort after five payload bytes: no write, outputs cleared, clean restart
        send_byte(8'h20, 1'b0);
        send_byte(8'h01, 1'b0);
        for (int j = 0; j < 5; j++) send_byte(8'(j + 1), 1'b0);
        check("busy_before_abort", 64'(bus.busy), 64'd1);
        base_w = n_w;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_write", 64'(n_w - base_w), 64'd0);
        check("ready_after_abort", 64'(bus.s_ready), 64'd1);
        run_txn(vt[1]);
        run_txn(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
